// File: rtl/pwm_pkg.sv
// Shared constants and types for the PWM channel and its write-port sequencers.
package pwm_pkg;

  localparam int unsigned PWM_W   = 16;
  localparam int unsigned PWM_PW  = 8;
  localparam int unsigned SEL_W   = 2;

  localparam logic [SEL_W-1:0] SEL_NONE = 2'd0;
  localparam logic [SEL_W-1:0] SEL_CMP  = 2'd1;
  localparam logic [SEL_W-1:0] SEL_TOP  = 2'd2;
  localparam logic [SEL_W-1:0] SEL_CNT  = 2'd3;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_TOP,
    LOAD_CMP,
    LOAD_CNT,
    RUN,
    FINISH
  } ramp_state_t;

endpackage

// File: rtl/pwm_step_calc.sv
// Saturating next compare value: moves cur toward target by step, never passing target.
module pwm_step_calc #(
  parameter int unsigned W = 16
) (
  input  logic [W-1:0] cur,
  input  logic [W-1:0] step,
  input  logic [W-1:0] target,
  input  logic         down,
  output logic [W-1:0] next_cmp
);

  logic [W:0] sum;
  logic [W:0] diff;

  assign sum  = {1'b0, cur} + {1'b0, step};
  assign diff = {1'b0, cur} - {1'b0, step};

  always_comb begin
    next_cmp = target;
    if (step != '0) begin
      if (!down) begin
        if (sum < {1'b0, target}) next_cmp = sum[W-1:0];
      end else begin
        // diff[W] set means cur - step went below 0, which saturates to target
        if (!diff[W] && (diff > {1'b0, target})) next_cmp = diff[W-1:0];
      end
    end
  end

endmodule

// File: rtl/pwm_ramp_ctrl.sv
// Drives a PWM write port: loads top/cmp/cnt, then ramps cmp toward a target on period wraps.
module pwm_ramp_ctrl
  import pwm_pkg::*;
#(
  parameter int unsigned W  = 16,
  parameter int unsigned PW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          abort,
  input  logic [W-1:0]  cfg_top,
  input  logic [W-1:0]  cfg_start_cmp,
  input  logic [W-1:0]  cfg_target_cmp,
  input  logic [W-1:0]  cfg_step,
  input  logic [PW-1:0] cfg_periods,
  input  logic [W-1:0]  pwm_cnt,
  output logic [W-1:0]  pwm_d,
  output logic [1:0]    pwm_sel,
  output logic [W-1:0]  cur_cmp,
  output logic          busy,
  output logic          done
);

  ramp_state_t   state_q, state_d;
  logic [W-1:0]  top_q, start_q, tgt_q, step_q;
  logic [PW-1:0] per_q;
  logic          down_q;
  logic [PW-1:0] pcnt_q, pcnt_d;
  logic [W-1:0]  cur_q, cur_d;
  logic          latch;

  logic [W-1:0]  next_cmp;
  logic          wrap;
  logic [PW-1:0] per_eff;
  logic          step_hit;

  pwm_step_calc #(
    .W(W)
  ) u_step_calc (
    .cur     (cur_q),
    .step    (step_q),
    .target  (tgt_q),
    .down    (down_q),
    .next_cmp(next_cmp)
  );

  // Same condition the PWM uses to reset its counter, so the cmp write shares the wrap edge
  assign wrap     = (pwm_cnt >= top_q);
  assign per_eff  = (per_q == '0) ? {{(PW-1){1'b0}}, 1'b1} : per_q;
  assign step_hit = wrap && (({1'b0, pcnt_q} + {{PW{1'b0}}, 1'b1}) == {1'b0, per_eff});

  always_comb begin
    state_d = state_q;
    pcnt_d  = pcnt_q;
    cur_d   = cur_q;
    latch   = 1'b0;
    pwm_sel = SEL_NONE;
    pwm_d   = '0;
    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          latch   = 1'b1;
          state_d = LOAD_TOP;
        end
      end
      LOAD_TOP: begin
        pwm_sel = SEL_TOP;
        pwm_d   = top_q;
        state_d = LOAD_CMP;
      end
      LOAD_CMP: begin
        pwm_sel = SEL_CMP;
        pwm_d   = start_q;
        cur_d   = start_q;
        state_d = LOAD_CNT;
      end
      LOAD_CNT: begin
        pwm_sel = SEL_CNT;
        pcnt_d  = '0;
        state_d = (start_q == tgt_q) ? FINISH : RUN;
      end
      RUN: begin
        if (step_hit) begin
          pwm_sel = SEL_CMP;
          pwm_d   = next_cmp;
          cur_d   = next_cmp;
          pcnt_d  = '0;
          if (next_cmp == tgt_q) state_d = FINISH;
        end else if (wrap) begin
          pcnt_d = pcnt_q + 1'b1;
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Abort wins over any write that would otherwise land this cycle
    if (abort && (state_q != IDLE)) begin
      state_d = IDLE;
      pcnt_d  = pcnt_q;
      cur_d   = cur_q;
      pwm_sel = SEL_NONE;
      pwm_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pcnt_q  <= '0;
      cur_q   <= '0;
      top_q   <= '0;
      start_q <= '0;
      tgt_q   <= '0;
      step_q  <= '0;
      per_q   <= '0;
      down_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pcnt_q  <= pcnt_d;
      cur_q   <= cur_d;
      if (latch) begin
        top_q   <= cfg_top;
        start_q <= cfg_start_cmp;
        tgt_q   <= cfg_target_cmp;
        step_q  <= cfg_step;
        per_q   <= cfg_periods;
        down_q  <= (cfg_target_cmp < cfg_start_cmp);
      end
    end
  end

  assign cur_cmp = cur_q;
  assign busy    = (state_q != IDLE) && (state_q != FINISH);
  assign done    = (state_q == FINISH);

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Directed bench for pwm_ramp_ctrl driving a small behavioural PWM channel.
module tb_pwm_ramp_ctrl;
  import pwm_pkg::*;

  localparam int W  = 16;
  localparam int PW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [W-1:0]  cfg_top = '0, cfg_start_cmp = '0, cfg_target_cmp = '0, cfg_step = '0;
  logic [PW-1:0] cfg_periods = '0;
  logic [W-1:0]  pwm_cnt, pwm_d, cur_cmp;
  logic [1:0]    pwm_sel;
  logic          busy, done;

  pwm_ramp_ctrl #(
    .W (W),
    .PW(PW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .abort         (abort),
    .cfg_top       (cfg_top),
    .cfg_start_cmp (cfg_start_cmp),
    .cfg_target_cmp(cfg_target_cmp),
    .cfg_step      (cfg_step),
    .cfg_periods   (cfg_periods),
    .pwm_cnt       (pwm_cnt),
    .pwm_d         (pwm_d),
    .pwm_sel       (pwm_sel),
    .cur_cmp       (cur_cmp),
    .busy          (busy),
    .done          (done)
  );

  always #5 clk = ~clk;

  // Behavioural PWM channel on the write port
  logic [W-1:0] m_top, m_cmp, m_cnt;
  logic         pwm_out;
  assign pwm_cnt = m_cnt;
  assign pwm_out = (m_cnt < m_cmp);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_top <= '0;
      m_cmp <= '0;
      m_cnt <= '0;
    end else begin
      if (pwm_sel == SEL_CNT) m_cnt <= pwm_d;
      else m_cnt <= (m_cnt >= m_top) ? '0 : m_cnt + 1'b1;
      if (pwm_sel == SEL_TOP) m_top <= pwm_d;
      if (pwm_sel == SEL_CMP) m_cmp <= pwm_d;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int unsigned log_sel[$], log_d[$], log_cyc[$], log_cnt[$];
  int          done_cnt = 0;
  int          done_cyc = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (pwm_sel != SEL_NONE) begin
        log_sel.push_back(pwm_sel);
        log_d.push_back(pwm_d);
        log_cyc.push_back(cyc);
        log_cnt.push_back(m_cnt);
      end
      if (done) begin
        done_cnt = done_cnt + 1;
        done_cyc = cyc;
      end
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clear_log();
    log_sel.delete();
    log_d.delete();
    log_cyc.delete();
    log_cnt.delete();
    done_cnt = 0;
    done_cyc = 0;
  endtask

  task automatic chk_wr(input string tn, input int i, input int sel, input int d);
    if (i < log_sel.size()) begin
      check($sformatf("%s_w%0d_sel", tn, i), log_sel[i], sel);
      check($sformatf("%s_w%0d_d", tn, i), log_d[i], d);
    end else begin
      check($sformatf("%s_w%0d_missing", tn, i), log_sel.size(), i + 1);
    end
  endtask

  function automatic int wr_cyc(input int i);
    return (i < log_cyc.size()) ? int'(log_cyc[i]) : -1;
  endfunction

  task automatic pulse_start(input int top, input int s, input int t, input int st,
                             input int per);
    @(negedge clk);
    cfg_top        = W'(top);
    cfg_start_cmp  = W'(s);
    cfg_target_cmp = W'(t);
    cfg_step       = W'(st);
    cfg_periods    = PW'(per);
    start          = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_seq(input string tn, input int top, input int s, input int t,
                         input int st, input int per);
    int k;
    clear_log();
    pulse_start(top, s, t, st, per);
    k = 0;
    while (busy && k < 2000) begin
      @(negedge clk);
      k++;
    end
    check({tn, "_timeout"}, (k < 2000), 1);
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic wait_writes(input string tn, input int n);
    int k;
    k = 0;
    while (log_sel.size() < n && k < 200) begin
      @(negedge clk);
      k++;
    end
    check({tn, "_wait"}, (log_sel.size() >= n), 1);
  endtask

  initial begin
    int hi;
    // Reset state
    repeat (2) @(negedge clk);
    check("rst_sel", pwm_sel, 0);
    check("rst_d", pwm_d, 0);
    check("rst_cur", cur_cmp, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Ramp up 2 -> 5 -> 8, top 9
    run_seq("up", 9, 2, 8, 3, 1);
    check("up_nwr", log_sel.size(), 5);
    chk_wr("up", 0, 2, 9);
    chk_wr("up", 1, 1, 2);
    chk_wr("up", 2, 3, 0);
    chk_wr("up", 3, 1, 5);
    chk_wr("up", 4, 1, 8);
    if (log_cnt.size() >= 5) begin
      check("up_cnt_w3", log_cnt[3], 9);
      check("up_cnt_w4", log_cnt[4], 9);
    end
    check("up_lat_w3", wr_cyc(3) - wr_cyc(0), 12);
    check("up_done_n", done_cnt, 1);
    check("up_cur", cur_cmp, 8);
    check("up_busy", busy, 0);
    hi = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      hi += int'(pwm_out);
    end
    check("up_duty80", hi, 8);

    // Ramp down with saturation at 1, two wraps per step
    run_seq("dn", 4, 10, 1, 4, 2);
    check("dn_nwr", log_sel.size(), 6);
    chk_wr("dn", 0, 2, 4);
    chk_wr("dn", 1, 1, 10);
    chk_wr("dn", 2, 3, 0);
    chk_wr("dn", 3, 1, 6);
    chk_wr("dn", 4, 1, 2);
    chk_wr("dn", 5, 1, 1);
    check("dn_lat_w3", wr_cyc(3) - wr_cyc(0), 12);
    check("dn_gap_w4", wr_cyc(4) - wr_cyc(3), 10);
    check("dn_gap_w5", wr_cyc(5) - wr_cyc(4), 10);
    check("dn_done_n", done_cnt, 1);
    check("dn_cur", cur_cmp, 1);

    // step = 0 jumps to target on the first wrap; periods = 0 acts as 1
    run_seq("s0", 5, 2, 7, 0, 0);
    check("s0_nwr", log_sel.size(), 4);
    chk_wr("s0", 3, 1, 7);
    check("s0_lat_w3", wr_cyc(3) - wr_cyc(0), 8);
    check("s0_done_n", done_cnt, 1);

    // start == target: loads only, done three cycles after LOAD_TOP
    run_seq("eq", 5, 4, 4, 2, 1);
    check("eq_nwr", log_sel.size(), 3);
    chk_wr("eq", 1, 1, 4);
    check("eq_done_lat", done_cyc - wr_cyc(0), 3);
    check("eq_done_n", done_cnt, 1);

    // top = 0: every cycle wraps
    run_seq("t0", 0, 0, 3, 1, 1);
    check("t0_nwr", log_sel.size(), 6);
    chk_wr("t0", 3, 1, 1);
    chk_wr("t0", 4, 1, 2);
    chk_wr("t0", 5, 1, 3);
    check("t0_lat_w3", wr_cyc(3) - wr_cyc(0), 3);
    check("t0_gap_w5", wr_cyc(5) - wr_cyc(3), 2);

    // Abort in RUN after the first step write
    clear_log();
    pulse_start(9, 2, 8, 3, 1);
    wait_writes("ab", 4);
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("ab_busy", busy, 0);
    check("ab_sel", pwm_sel, 0);
    check("ab_cur", cur_cmp, 5);
    repeat (30) @(negedge clk);
    check("ab_done_n", done_cnt, 0);
    check("ab_nwr", log_sel.size(), 4);
    check("ab_pwm_cmp", m_cmp, 5);
    run_seq("re", 9, 2, 8, 3, 1);
    check("re_nwr", log_sel.size(), 5);
    chk_wr("re", 3, 1, 5);
    chk_wr("re", 4, 1, 8);
    check("re_done_n", done_cnt, 1);

    // start while busy is ignored; async reset mid-RUN clears outputs at once
    clear_log();
    pulse_start(9, 2, 8, 3, 1);
    repeat (4) @(negedge clk);
    pulse_start(3, 1, 2, 1, 1);
    wait_writes("rb", 4);
    chk_wr("rb", 3, 1, 5);
    if (log_cnt.size() >= 4) check("rb_cnt_w3", log_cnt[3], 9);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rb_sel", pwm_sel, 0);
    check("rb_d", pwm_d, 0);
    check("rb_cur", cur_cmp, 0);
    check("rb_busy", busy, 0);
    check("rb_done", done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rb_idle_busy", busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
